pir_adc_sequencer: RTL
======================

Name: pir_adc_sequencer

Overview:
Upstream front-end for the PIR motion controller. It scans three PIR analog channels through a shared single-channel ADC with a start/done handshake, once every SAMPLE_PERIOD cycles. Each conversion is scaled to a 0..MAX_LEVEL 7-bit level and smoothed. The result is held on pir_sensor_1..3, which the motion controller averages and compares against its threshold of 50.

Parameters:
ADC_WIDTH, 10, ADC result width; must be ≥ 7.
SAMPLE_PERIOD, 16, cycles between scan starts; must be ≥ 12.
ADC_TIMEOUT, 32, max cycles to wait for adc_done per channel.
MAX_LEVEL, 100, saturation ceiling of the published level.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
turn  in  1  system enable; 0 halts scanning
adc_start  out  1  one-cycle conversion request
adc_channel  out  2  channel being converted (0,1,2); valid while adc_start is high
adc_done  in  1  one-cycle conversion complete
adc_data  in  ADC_WIDTH  conversion result; valid with adc_done
pir_sensor_1  out  7  smoothed level, channel 0
pir_sensor_2  out  7  smoothed level, channel 1
pir_sensor_3  out  7  smoothed level, channel 2
frame_valid  out  1  one-cycle pulse after a full 3-channel scan
adc_fault  out  1  sticky: a conversion timed out
fault_channel  out  2  channel of the most recent timeout
scan_overrun  out  1  sticky: a tick arrived during a scan

Behaviour:
- Reset (asynchronous, any state):
  - all outputs, counters and seeded flags go to 0; FSM goes to IDLE.
  - Faults are cleared only by rst.
- Period counter:
  - while turn=1, counts 0..SAMPLE_PERIOD-1 and wraps; tick=1 when count==SAMPLE_PERIOD-1.
  - held at 0 while turn=0, so the first tick occurs SAMPLE_PERIOD cycles after turn rises.
- FSM states: IDLE, REQUEST, WAIT_DONE, PUBLISH.
  - IDLE: on tick, ch←0 and go to REQUEST.
  - REQUEST: adc_start=1 and adc_channel=ch for exactly one cycle; load timeout counter with 0; go to WAIT_DONE.
  - WAIT_DONE, adc_done=1: update channel ch at that edge. If ch<2, ch←ch+1 and go to REQUEST; else go to PUBLISH.
  - WAIT_DONE, timeout counter reaches ADC_TIMEOUT-1 without adc_done:
    - adc_fault←1, fault_channel←ch;
    - channel output holds its old value;
    - advance exactly as for done (next REQUEST, or PUBLISH after ch 2).
  - PUBLISH: frame_valid=1 for one cycle, including after a faulted channel; go to IDLE.
- Conversion arithmetic:
  - lvl = adc_data[ADC_WIDTH-1 -: 7].
  - If lvl > MAX_LEVEL, then lvl = MAX_LEVEL.
- Smoothing:
  - channel not yet seeded: out←lvl and seeded←1.
  - otherwise: out←(out+lvl)>>1, with an 8-bit intermediate and truncation.
  - Output never exceeds MAX_LEVEL.
- Latency: new level is visible on the pir_sensor port the cycle after the adc_done edge. frame_valid asserts the cycle after the channel-2 update.
- Handshake rules:
  - adc_done outside WAIT_DONE is ignored.
  - adc_done arriving on the same edge the timeout fires counts as done; no fault is raised.
  - adc_start is never reissued for a channel within one scan.
- Ticks outside IDLE are dropped and set scan_overrun←1.
- turn falling mid-scan:
  - next edge returns FSM to IDLE and clears adc_start;
  - no frame_valid; outputs and seeded flags hold;
  - a pending adc_done is ignored.
- turn=0 in IDLE: nothing happens; outputs hold their last values.

Test Plan:
1. Basic scan: rst, turn=1; ADC model answers 3 cycles after each start with data 400, 800, 1023.
   - Expected: outputs 50, 100, 100 (800>>3=100, 1023→127 clamped to 100); one frame_valid; adc_channel sequence 0,1,2; first adc_start at cycle SAMPLE_PERIOD.
2. Smoothing: following scan with data 0, 400, 8 on channels 0, 1, 2.
   - Expected: pir_sensor_1=25, pir_sensor_2=75, pir_sensor_3=50.
3. Timeout: ADC never answers channel 1.
   - Expected: after ADC_TIMEOUT cycles adc_fault=1 and fault_channel=1; pir_sensor_2 unchanged; channel 2 still converted; frame_valid pulses.
4. Done/timeout race: adc_done on the exact timeout edge.
   - Expected: adc_fault stays 0 and the channel updates.
5. Overrun and abort:
   - SAMPLE_PERIOD=12 with a 4-cycle ADC response → scan_overrun=1.
   - Separately, turn→0 during channel 1 → FSM returns to IDLE, no frame_valid, outputs hold.
6. Async reset mid-WAIT_DONE:
   - Expected: outputs clear immediately, without a clock edge. The next scan seeds directly: data 400 → 50, not 25.

Source files
------------

// File: rtl/pir_adc_sequencer.sv
// pir_adc_sequencer: scans three PIR channels through a shared ADC once per
// sample period, scales each result to a 0..MAX_LEVEL level, smooths it and
// publishes it on pir_sensor_1..3 together with a frame strobe and fault flags.
module pir_adc_sequencer #(
    parameter int ADC_WIDTH     = 10,
    parameter int SAMPLE_PERIOD = 16,
    parameter int ADC_TIMEOUT   = 32,
    parameter int MAX_LEVEL     = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 turn,
    output logic                 adc_start,
    output logic [1:0]           adc_channel,
    input  logic                 adc_done,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic [6:0]           pir_sensor_1,
    output logic [6:0]           pir_sensor_2,
    output logic [6:0]           pir_sensor_3,
    output logic                 frame_valid,
    output logic                 adc_fault,
    output logic [1:0]           fault_channel,
    output logic                 scan_overrun
);

    localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMO_W = $clog2(ADC_TIMEOUT + 1);
    localparam int SHIFT = ADC_WIDTH - 7;

    // Any raw code at or above this value maps to a level above MAX_LEVEL.
    // Comparing the full word keeps every ADC bit in play without a slice.
    localparam bit                 SAT_EN  = (MAX_LEVEL < 127);
    localparam logic [ADC_WIDTH-1:0] SAT_THR = ADC_WIDTH'((MAX_LEVEL + 1) << SHIFT);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        WAIT_DONE,
        PUBLISH
    } state_t;

    state_t             state, next_state;
    logic [CNT_W-1:0]   period_cnt;
    logic [TMO_W-1:0]   tmo_cnt;
    logic [1:0]         ch;
    logic [2:0]         seeded;
    logic               tick;
    logic               take_done;
    logic               take_timeout;
    logic [6:0]         lvl;

    // Top 7 bits of the conversion, clamped to the published ceiling.
    function automatic logic [6:0] sat_level(input logic [ADC_WIDTH-1:0] d);
        if (SAT_EN && (d >= SAT_THR))
            return 7'(MAX_LEVEL);
        return d[ADC_WIDTH-1 -: 7];
    endfunction

    // Two-point running average with an 8-bit sum and truncating divide.
    function automatic logic [6:0] smooth(input logic [6:0] old_v, input logic [6:0] new_v);
        logic [7:0] sum;
        sum = {1'b0, old_v} + {1'b0, new_v};
        return 7'(sum >> 1);
    endfunction

    assign lvl         = sat_level(adc_data);
    assign tick        = turn && (period_cnt == CNT_W'(SAMPLE_PERIOD - 1));
    assign adc_channel = ch;

    // Free-running period counter, parked at zero while the system is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            period_cnt <= '0;
        else if (!turn || (period_cnt == CNT_W'(SAMPLE_PERIOD - 1)))
            period_cnt <= '0;
        else
            period_cnt <= period_cnt + 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic and handshake strobes; turn low aborts any scan.
    always_comb begin
        next_state   = state;
        adc_start    = 1'b0;
        frame_valid  = 1'b0;
        take_done    = 1'b0;
        take_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (tick)
                    next_state = REQUEST;
            end
            REQUEST: begin
                adc_start  = 1'b1;
                next_state = turn ? WAIT_DONE : IDLE;
            end
            WAIT_DONE: begin
                if (!turn) begin
                    next_state = IDLE;
                end else if (adc_done) begin
                    take_done  = 1'b1;
                    next_state = (ch == 2'd2) ? PUBLISH : REQUEST;
                end else if (tmo_cnt == TMO_W'(ADC_TIMEOUT - 1)) begin
                    take_timeout = 1'b1;
                    next_state   = (ch == 2'd2) ? PUBLISH : REQUEST;
                end
            end
            PUBLISH: begin
                frame_valid = 1'b1;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Channel index, timeout counter, published levels and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch            <= 2'd0;
            tmo_cnt       <= '0;
            seeded        <= 3'b000;
            pir_sensor_1  <= 7'd0;
            pir_sensor_2  <= 7'd0;
            pir_sensor_3  <= 7'd0;
            adc_fault     <= 1'b0;
            fault_channel <= 2'd0;
            scan_overrun  <= 1'b0;
        end else begin
            if (tick && (state != IDLE))
                scan_overrun <= 1'b1;

            if ((state == IDLE) && tick)
                ch <= 2'd0;

            if (state == REQUEST)
                tmo_cnt <= '0;
            else if (state == WAIT_DONE)
                tmo_cnt <= tmo_cnt + 1'b1;

            if (take_done) begin
                case (ch)
                    2'd0: pir_sensor_1 <= seeded[0] ? smooth(pir_sensor_1, lvl) : lvl;
                    2'd1: pir_sensor_2 <= seeded[1] ? smooth(pir_sensor_2, lvl) : lvl;
                    default: pir_sensor_3 <= seeded[2] ? smooth(pir_sensor_3, lvl) : lvl;
                endcase
                seeded[ch] <= 1'b1;
            end

            if (take_timeout) begin
                adc_fault     <= 1'b1;
                fault_channel <= ch;
            end

            if ((take_done || take_timeout) && (ch != 2'd2))
                ch <= ch + 2'd1;
        end
    end

endmodule
